// File: rtl/usb_tx_stream_arbiter.sv
// Packet-level round-robin arbiter that multiplexes N_SRC AXI-stream sources onto one registered USB TX stream.
// Optional stall watchdog enabled by defining USB_TX_ARB_WDOG_EN.
module usb_tx_stream_arbiter #(
   parameter int N_SRC       = 2,
   parameter int WDOG_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_SRC-1:0]     s_tvalid,
   output logic [N_SRC-1:0]     s_tready,
   input  logic [32*N_SRC-1:0]  s_tdata,
   input  logic [4*N_SRC-1:0]   s_tkeep,
   input  logic [N_SRC-1:0]     s_tlast,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [31:0]          m_tdata,
   output logic [3:0]           m_tkeep,
   output logic                 m_tlast,
   output logic [N_SRC-1:0]     grant,
   output logic                 wdog_err
);

   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   if (N_SRC < 2 || N_SRC > 4 || WDOG_CYCLES < 1) begin : g_param_check
      $error("usb_tx_stream_arbiter: N_SRC must be 2..4 and WDOG_CYCLES >= 1");
   end

`ifdef USB_TX_ARB_WDOG_EN
   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_FLUSH} state_t;
   localparam int CW = $clog2(WDOG_CYCLES + 1);
   logic [CW-1:0] wdog_cnt;
   logic          wdog_q;
`else
   typedef enum logic {ST_IDLE, ST_PASS} state_t;
`endif

   state_t        state;
   logic [PW-1:0] owner;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_next;
   logic [PW-1:0] pick_idx;
   logic          pick_any;
   logic          slot_free;
   logic          accept;
   logic          sel_valid;
   logic [31:0]   sel_data;
   logic [3:0]    sel_keep;
   logic          sel_last;

   assign slot_free = !m_tvalid || m_tready;
   assign s_tready  = (state == ST_PASS && slot_free) ? grant : '0;
   assign accept    = (state == ST_PASS) && slot_free && sel_valid;
   assign rr_next   = (owner == PW'(N_SRC - 1)) ? '0 : owner + PW'(1);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_last  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (owner == PW'(i)) begin
            sel_valid = s_tvalid[i];
            sel_data  = s_tdata[32*i +: 32];
            sel_keep  = s_tkeep[4*i +: 4];
            sel_last  = s_tlast[i];
         end
      end
   end

   // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < N_SRC; k++) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!pick_any && s_tvalid[idx]) begin
            pick_any = 1'b1;
            pick_idx = PW'(idx);
         end
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         grant    <= '0;
         owner    <= '0;
         rr_ptr   <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
         m_tlast  <= 1'b0;
`ifdef USB_TX_ARB_WDOG_EN
         wdog_cnt <= '0;
         wdog_q   <= 1'b0;
`endif
      end else begin
`ifdef USB_TX_ARB_WDOG_EN
         wdog_q <= 1'b0;
`endif
         // A consumed beat with nothing new behind it leaves the output empty.
         if (slot_free) m_tvalid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant <= N_SRC'(1) << pick_idx;
                  owner <= pick_idx;
                  state <= ST_PASS;
`ifdef USB_TX_ARB_WDOG_EN
                  wdog_cnt <= '0;
`endif
               end
            end

            ST_PASS: begin
               if (accept) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= sel_data;
                  m_tkeep  <= sel_keep;
                  m_tlast  <= sel_last;
`ifdef USB_TX_ARB_WDOG_EN
                  wdog_cnt <= '0;
`endif
                  if (sel_last) begin
                     state  <= ST_IDLE;
                     grant  <= '0;
                     rr_ptr <= rr_next;
                  end
               end
`ifdef USB_TX_ARB_WDOG_EN
               else if (!sel_valid) begin
                  if (wdog_cnt == CW'(WDOG_CYCLES - 1)) begin
                     wdog_cnt <= '0;
                     state    <= ST_FLUSH;
                  end else begin
                     wdog_cnt <= wdog_cnt + CW'(1);
                  end
               end
`endif
            end

`ifdef USB_TX_ARB_WDOG_EN
            // Terminate the stalled packet with an empty tlast beat so the host sees a clean boundary.
            ST_FLUSH: begin
               if (slot_free) begin
                  m_tvalid <= 1'b1;
                  m_tdata  <= '0;
                  m_tkeep  <= 4'b0000;
                  m_tlast  <= 1'b1;
                  wdog_q   <= 1'b1;
                  grant    <= '0;
                  rr_ptr   <= rr_next;
                  state    <= ST_IDLE;
               end
            end
`endif

            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef USB_TX_ARB_WDOG_EN
   assign wdog_err = wdog_q;
`else
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_stream_arbiter.sv
// Self-checking bench for usb_tx_stream_arbiter: directed scenarios plus randomized rounds
// scored against a packet-level round-robin model (watchdog scenario with USB_TX_ARB_WDOG_EN).
module tb_usb_tx_stream_arbiter;

   localparam int N    = 3;
   localparam int WDOG = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tready;
   logic [32*N-1:0] s_tdata;
   logic [4*N-1:0]  s_tkeep;
   logic [N-1:0]    s_tlast;
   logic            m_tvalid;
   logic            m_tready;
   logic [31:0]     m_tdata;
   logic [3:0]      m_tkeep;
   logic            m_tlast;
   logic [N-1:0]    grant;
   logic            wdog_err;

   usb_tx_stream_arbiter #(.N_SRC(N), .WDOG_CYCLES(WDOG)) dut (
      .clk(clk), .rstn(rstn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast),
      .grant(grant), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   int    wdog_pulses = 0;
   int    model_ptr   = 0;
   int    ready_mode  = 0;   // 0: always ready, 1: toggle 1,0,..., 2: random
   bit    tog_phase   = 1'b1;
   bit    gap_en      = 1'b0;
   bit    hold [N];
   bit    mid  [N];
   bit    prev_stall  = 1'b0;
   logic [37:0] prev_bus;

   beat_t src_q  [N][$];     // what each source driver still has to send
   beat_t pend_q [N][$];     // packets not yet placed in the expected order
   beat_t out_exp[$];
   int    in_exp_src[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      return b;
   endfunction

   task automatic push_beat(input int src, input beat_t b);
      src_q[src].push_back(b);
      pend_q[src].push_back(b);
   endtask

   task automatic push_rand_packet(input int src, input int len);
      for (int b = 0; b < len; b++)
         push_beat(src, mk($urandom, 4'($urandom), b == len - 1));
   endtask

   // Reference: every pending source is requesting, so packets leave in strict round-robin order.
   task automatic schedule();
      forever begin
         int owner;
         owner = -1;
         for (int k = 0; k < N; k++) begin
            int s;
            s = (model_ptr + k) % N;
            if (owner < 0 && pend_q[s].size() > 0) owner = s;
         end
         if (owner < 0) break;
         while (pend_q[owner].size() > 0) begin
            beat_t b;
            b = pend_q[owner].pop_front();
            in_exp_src.push_back(owner);
            out_exp.push_back(b);
            if (b.last) break;
         end
         model_ptr = (owner + 1) % N;
      end
   endtask

   function automatic int src_total();
      int t;
      t = 0;
      for (int i = 0; i < N; i++) t += src_q[i].size();
      return t;
   endfunction

   task automatic step();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         bit go;
         go = src_q[i].size() > 0 && !hold[i] &&
              !(mid[i] && gap_en && ($urandom_range(0, 99) < 30));
         s_tvalid[i] = go;
         if (go) begin
            s_tdata[32*i +: 32] = src_q[i][0].data;
            s_tkeep[4*i +: 4]   = src_q[i][0].keep;
            s_tlast[i]          = src_q[i][0].last;
         end else begin
            s_tdata[32*i +: 32] = $urandom;
            s_tkeep[4*i +: 4]   = 4'($urandom);
            s_tlast[i]          = 1'($urandom);
         end
      end
      case (ready_mode)
         0: m_tready = 1'b1;
         1: begin m_tready = tog_phase; tog_phase = ~tog_phase; end
         default: m_tready = ($urandom_range(0, 99) < 70);
      endcase
      #1;
      if (!rstn) return;
      if (wdog_err) wdog_pulses++;
      check("grant_onehot0", $onehot0(grant), 1);
      check("tready_only_owner", s_tready & ~grant, 0);
      for (int i = 0; i < N; i++) begin
         if (s_tvalid[i] && s_tready[i]) begin
            beat_t b;
            check("in_beat_expected", in_exp_src.size() > 0, 1);
            if (in_exp_src.size() > 0) check("in_owner", i, in_exp_src.pop_front());
            b = src_q[i].pop_front();
            mid[i] = !b.last;
         end
      end
      if (prev_stall) check("stall_hold", {m_tdata, m_tkeep, m_tlast, m_tvalid}, prev_bus);
      if (m_tvalid && m_tready) begin
         check("out_beat_expected", out_exp.size() > 0, 1);
         if (out_exp.size() > 0) check("out_beat", {m_tdata, m_tkeep, m_tlast}, out_exp.pop_front());
      end
      prev_stall = m_tvalid && !m_tready;
      prev_bus   = {m_tdata, m_tkeep, m_tlast, m_tvalid};
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((out_exp.size() > 0 || src_total() > 0) && n < budget) begin
         step();
         n++;
      end
      check("drain_left", out_exp.size() + src_total(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn     = 1'b0;
      s_tvalid = '0;
      #1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tkeep", m_tkeep, 0);
      check("rst_grant", grant, 0);
      check("rst_wdog_err", wdog_err, 0);
      check("rst_s_tready", s_tready, 0);
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         pend_q[i].delete();
         mid[i]  = 1'b0;
         hold[i] = 1'b0;
      end
      in_exp_src.delete();
      out_exp.delete();
      model_ptr  = 0;
      prev_stall = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn     = 1'b0;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      m_tready = 1'b1;
      for (int i = 0; i < N; i++) begin hold[i] = 1'b0; mid[i] = 1'b0; end
      do_reset();

      // Single source, 3 beats: 2-cycle latency, grant = s0, beats passed unchanged.
      ready_mode = 0;
      push_beat(0, mk(32'h1111_1111, 4'hF, 1'b0));
      push_beat(0, mk(32'h2222_2222, 4'hF, 1'b0));
      push_beat(0, mk(32'h3333_3333, 4'b0011, 1'b1));
      schedule();
      step();
      check("lat_first_cycle_idle", m_tvalid, 0);
      step();
      check("lat_grant_s0", grant, 3'b001);
      check("lat_one_cycle", m_tvalid, 0);
      step();
      check("lat_two_cycles", m_tvalid, 1);
      drain(50);

      // Two sources requesting together from reset, two packets each.
      do_reset();
      push_rand_packet(0, 3);
      push_rand_packet(1, 2);
      push_rand_packet(0, 1);
      push_rand_packet(1, 4);
      schedule();
      check("rr_order_first", in_exp_src[0], 0);
      drain(100);

      // 4-beat packet with m_tready toggling.
      ready_mode = 1;
      tog_phase  = 1'b1;
      push_rand_packet(2, 4);
      schedule();
      drain(100);
      ready_mode = 0;

`ifndef USB_TX_ARB_WDOG_EN
      // Owner drops tvalid for 50 cycles mid-packet while s1 waits.
      push_rand_packet(0, 4);
      schedule();
      for (int n = 0; n < 20 && src_q[0].size() > 3; n++) step();
      check("hold_first_beat_taken", src_q[0].size(), 3);
      hold[0] = 1'b1;
      push_rand_packet(1, 2);
      schedule();
      for (int n = 0; n < 50; n++) begin
         step();
         if (n % 10 == 0) check("hold_grant_kept", grant, 3'b001);
      end
      hold[0] = 1'b0;
      drain(100);
`endif

      // Randomized rounds against the round-robin model.
      gap_en     = 1'b1;
      ready_mode = 2;
      for (int r = 0; r < 12; r++) begin
         bit any;
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               int np;
               np  = $urandom_range(1, 3);
               any = 1'b1;
               for (int p = 0; p < np; p++) push_rand_packet(i, $urandom_range(1, 6));
            end
         end
         if (!any) push_rand_packet(r % N, $urandom_range(1, 6));
         schedule();
         drain(2000);
      end
      gap_en     = 1'b0;
      ready_mode = 0;

      // Reset mid-packet, then s0 must win the tie with s1.
      push_rand_packet(0, 6);
      push_rand_packet(1, 2);
      schedule();
      for (int n = 0; n < 20 && src_q[0].size() > 3; n++) step();
      check("mid_pkt_progress", src_q[0].size(), 3);
      do_reset();
      push_rand_packet(0, 2);
      push_rand_packet(1, 2);
      schedule();
      check("post_rst_tie_s0", in_exp_src[0], 0);
      drain(100);

`ifdef USB_TX_ARB_WDOG_EN
      // Stalled owner: forced empty tlast beat, single wdog_err pulse, then s1.
      do_reset();
      wdog_pulses = 0;
      begin
         beat_t b0;
         b0 = mk(32'hDEAD_BEEF, 4'hF, 1'b0);
         src_q[0].push_back(b0);
         in_exp_src.push_back(0);
         out_exp.push_back(b0);
         out_exp.push_back(mk(32'h0, 4'b0000, 1'b1));
      end
      for (int n = 0; n < 20 && src_q[0].size() > 0; n++) step();
      for (int b = 0; b < 2; b++) begin
         beat_t b1;
         b1 = mk($urandom, 4'hF, b == 1);
         src_q[1].push_back(b1);
         in_exp_src.push_back(1);
         out_exp.push_back(b1);
      end
      drain(200);
      check("wdog_pulse_once", wdog_pulses, 1);
`else
      check("wdog_never", wdog_pulses, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
